// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, state codes,
// datapath select values, exception causes and the per-opcode ALU selection.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_ANDI = 4'd6;
  localparam logic [3:0] OP_ORI  = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd11;
  localparam logic [3:0] OP_J    = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_EXEC_R   = 4'd2;
  localparam state_t S_EXEC_I   = 4'd3;
  localparam state_t S_MEM_ADDR = 4'd4;
  localparam state_t S_MEM_RD   = 4'd5;
  localparam state_t S_MEM_WR   = 4'd6;
  localparam state_t S_WB_ALU   = 4'd7;
  localparam state_t S_WB_MEM   = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_JUMP     = 4'd10;
  localparam state_t S_EXC      = 4'd11;
  localparam state_t S_HALT     = 4'd12;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] SRCB_REGB     = 2'd0;
  localparam logic [1:0] SRCB_ZEXT     = 2'd1;
  localparam logic [1:0] SRCB_SEXT     = 2'd2;
  localparam logic [1:0] SRCB_SEXT_SH1 = 2'd3;

  localparam logic [1:0] PCSRC_INC    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_EXC    = 2'd3;

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_OVFL    = 2'd1;
  localparam logic [1:0] EXC_ILLEGAL = 2'd2;
  localparam logic [1:0] EXC_MEMTO   = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       alu_out_write;
    logic       epc_write;
    logic       halted;
  } ctrl_t;

  typedef struct packed {
    logic [1:0] src_b;
    logic [2:0] op;
    logic       ovfl_trap;
  } alu_sel_t;

  // ALU operand/operation for the execute step; only signed adds/subs trap.
  function automatic alu_sel_t alu_select(input logic [3:0] opcode);
    alu_sel_t sel;
    sel = '{src_b: SRCB_REGB, op: ALU_ADD, ovfl_trap: 1'b0};
    case (opcode)
      OP_ADD:  sel = '{src_b: SRCB_REGB, op: ALU_ADD, ovfl_trap: 1'b1};
      OP_SUB:  sel = '{src_b: SRCB_REGB, op: ALU_SUB, ovfl_trap: 1'b1};
      OP_AND:  sel = '{src_b: SRCB_REGB, op: ALU_AND, ovfl_trap: 1'b0};
      OP_OR:   sel = '{src_b: SRCB_REGB, op: ALU_OR,  ovfl_trap: 1'b0};
      OP_SLT:  sel = '{src_b: SRCB_REGB, op: ALU_SLT, ovfl_trap: 1'b0};
      OP_ADDI: sel = '{src_b: SRCB_SEXT, op: ALU_ADD, ovfl_trap: 1'b1};
      OP_ANDI: sel = '{src_b: SRCB_ZEXT, op: ALU_AND, ovfl_trap: 1'b0};
      OP_ORI:  sel = '{src_b: SRCB_ZEXT, op: ALU_OR,  ovfl_trap: 1'b0};
      default: sel = '{src_b: SRCB_REGB, op: ALU_ADD, ovfl_trap: 1'b0};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired_o flags the last cycle a wait may last
// before the access is abandoned.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic srst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // The current cycle is the MEM_TIMEOUT-th wait when count_q holds MEM_TIMEOUT-1.
  assign expired_o = (count_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM driving the 16-bit multicycle datapath control pins, with memory
// wait timeout and overflow / illegal-opcode / timeout exceptions.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Opcode,
  input  logic       Zero,
  input  logic       ovfl,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] AluOp,
  output logic       ALUOutWrite,
  output logic       EPCWrite,
  output logic [1:0] ExcCause,
  output logic       Halted,
  output logic [3:0] State
);

  state_t     state_q, state_d;
  logic [1:0] exc_cause_q, exc_cause_d;
  ctrl_t      ctrl, ctrl_out;
  alu_sel_t   alu_sel;
  logic       tmr_expired;
  logic       tmr_clear;
  logic       tmr_enable;

  always_comb begin
    ctrl        = '0;
    state_d     = state_q;
    exc_cause_d = exc_cause_q;
    alu_sel     = alu_select(Opcode);
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        if (MemReady) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PCSRC_INC;
          state_d       = S_DECODE;
        end else if (tmr_expired) begin
          state_d     = S_EXC;
          exc_cause_d = EXC_MEMTO;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b     = SRCB_SEXT_SH1;
        ctrl.alu_op        = ALU_ADD;
        ctrl.alu_out_write = 1'b1;
        case (Opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI:              state_d = S_EXEC_I;
          OP_LW, OP_SW:                          state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                        state_d = S_BRANCH;
          OP_J:                                  state_d = S_JUMP;
          OP_HALT:                               state_d = S_HALT;
          default: begin
            state_d     = S_EXC;
            exc_cause_d = EXC_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = alu_sel.src_b;
        ctrl.alu_op        = alu_sel.op;
        ctrl.alu_out_write = 1'b1;
        if (alu_sel.ovfl_trap && ovfl) begin
          state_d     = S_EXC;
          exc_cause_d = EXC_OVFL;
        end else begin
          state_d = S_WB_ALU;
        end
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_SEXT;
        ctrl.alu_op        = ALU_ADD;
        ctrl.alu_out_write = 1'b1;
        state_d            = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
        if (MemReady) begin
          state_d = S_WB_MEM;
        end else if (tmr_expired) begin
          state_d     = S_EXC;
          exc_cause_d = EXC_MEMTO;
        end
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
        if (MemReady) begin
          state_d = S_FETCH;
        end else if (tmr_expired) begin
          state_d     = S_EXC;
          exc_cause_d = EXC_MEMTO;
        end
      end
      S_WB_ALU: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_SUB;
        if ((Opcode == OP_BEQ && Zero) || (Opcode == OP_BNE && !Zero)) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PCSRC_ALUOUT;
        end
        state_d = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
        state_d       = S_FETCH;
      end
      S_EXC: begin
        ctrl.epc_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = PCSRC_EXC;
        state_d        = S_FETCH;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset abandons whatever is in flight, so nothing may reach the datapath.
  assign ctrl_out = Reset ? '0 : ctrl;

  assign tmr_clear  = Reset || (state_d != state_q);
  assign tmr_enable = !MemReady &&
                      (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (CLK),
    .srst     (Reset),
    .clear_i  (tmr_clear),
    .enable_i (tmr_enable),
    .expired_o(tmr_expired)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_FETCH;
      exc_cause_q <= EXC_NONE;
    end else begin
      state_q     <= state_d;
      exc_cause_q <= exc_cause_d;
    end
  end

  assign PCWrite     = ctrl_out.pc_write;
  assign PCSrc       = ctrl_out.pc_src;
  assign IorD        = ctrl_out.ior_d;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign IRWrite     = ctrl_out.ir_write;
  assign RegWrite    = ctrl_out.reg_write;
  assign MemToReg    = ctrl_out.mem_to_reg;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign AluOp       = ctrl_out.alu_op;
  assign ALUOutWrite = ctrl_out.alu_out_write;
  assign EPCWrite    = ctrl_out.epc_write;
  assign Halted      = ctrl_out.halted;
  assign ExcCause    = exc_cause_q;
  assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class,
// exceptions, memory waits/timeouts, HALT and reset, cycle by cycle.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset, Zero, ovfl, MemReady;
  logic [3:0] Opcode;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemToReg;
  logic       ALUSrcA, ALUOutWrite, EPCWrite, Halted;
  logic [1:0] PCSrc, ALUSrcB, ExcCause;
  logic [2:0] AluOp;
  logic [3:0] State;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int ce = 0;
  logic [23:0] exp_v;
  logic [23:0] obs;

  multicycle_control_unit #(.MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .ovfl(ovfl),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .AluOp(AluOp), .ALUOutWrite(ALUOutWrite),
    .EPCWrite(EPCWrite), .ExcCause(ExcCause), .Halted(Halted), .State(State)
  );

  always #5 CLK = ~CLK;

  assign obs = {State, PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                MemToReg, ALUSrcA, ALUSrcB, AluOp, ALUOutWrite, EPCWrite, ExcCause, Halted};

  // Packs hand-written expected output fields in the same order as obs.
  function automatic logic [23:0] ev(input int st, input int pcw, input int pcs,
      input int iod, input int mr, input int mw, input int irw, input int rw,
      input int m2r, input int sa, input int sb, input int op, input int aow,
      input int epc, input int cause, input int h);
    logic [3:0] s4 = st[3:0];
    logic [1:0] p2 = pcs[1:0];
    logic [1:0] b2 = sb[1:0];
    logic [2:0] o3 = op[2:0];
    logic [1:0] c2 = cause[1:0];
    return {s4, pcw[0], p2, iod[0], mr[0], mw[0], irw[0], rw[0], m2r[0], sa[0],
            b2, o3, aow[0], epc[0], c2, h[0]};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Opcode = 4'd0; Zero = 1'b0; ovfl = 1'b0; MemReady = 1'b1;
    cyc(); cyc();
    #1 exp_v = ev(0, 0,0,0,0,0,0,0,0,0,0,0,0,0, 0, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
    Reset = 1'b0;
    #1 exp_v = ev(0, 1,0,0,1,0,1,0,0,0,0,0,0,0, 0, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL reset_fetch: got %h want %h", obs, exp_v); end
    $display("test_reset: done");
  endtask

  task automatic test_add();
    Opcode = 4'd0; MemReady = 1'b1; ovfl = 1'b0;
    cyc();
    #1 exp_v = ev(1, 0,0,0,0,0,0,0,0,0,3,2,1,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL add_decode: got %h want %h", obs, exp_v); end
    cyc();
    #1 exp_v = ev(2, 0,0,0,0,0,0,0,0,1,0,2,1,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL add_exec: got %h want %h", obs, exp_v); end
    cyc();
    #1 exp_v = ev(7, 0,0,0,0,0,0,1,0,0,0,0,0,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL add_wb: got %h want %h", obs, exp_v); end
    cyc();
    #1 exp_v = ev(0, 1,0,0,1,0,1,0,0,0,0,0,0,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL add_refetch: got %h want %h", obs, exp_v); end
    $display("test_add: done");
  endtask

  // Opcodes 1..7 with expected execute state/selects; ovfl asserted where it must be ignored.
  task automatic test_alu_ops();
    int st_t [7] = '{2, 2, 2, 2, 3, 3, 3};
    int sb_t [7] = '{0, 0, 0, 0, 2, 1, 1};
    int op_t [7] = '{3, 0, 1, 4, 2, 0, 1};
    int ov_t [7] = '{0, 1, 1, 1, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      Opcode = 4'(i + 1); MemReady = 1'b1; ovfl = 1'b0;
      cyc(); cyc();
      ovfl = ov_t[i][0];
      #1 exp_v = ev(st_t[i], 0,0,0,0,0,0,0,0,1,sb_t[i],op_t[i],1,0, ce, 0);
      cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL alu_exec op%0d: got %h want %h", i + 1, obs, exp_v); end
      cyc(); ovfl = 1'b0;
      #1 exp_v = ev(7, 0,0,0,0,0,0,1,0,0,0,0,0,0, ce, 0);
      cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL alu_wb op%0d: got %h want %h", i + 1, obs, exp_v); end
      cyc();
    end
    $display("test_alu_ops: done");
  endtask

  task automatic test_addi_ovfl();
    Opcode = 4'd5; MemReady = 1'b1; ovfl = 1'b0;
    cyc(); cyc();
    ovfl = 1'b1;
    #1 exp_v = ev(3, 0,0,0,0,0,0,0,0,1,2,2,1,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL addi_exec: got %h want %h", obs, exp_v); end
    cyc(); ovfl = 1'b0; ce = 1;
    #1 exp_v = ev(11, 1,3,0,0,0,0,0,0,0,0,0,0,1, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL addi_exc: got %h want %h", obs, exp_v); end
    cyc();
    #1 exp_v = ev(0, 1,0,0,1,0,1,0,0,0,0,0,0,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL addi_refetch: got %h want %h", obs, exp_v); end
    $display("test_addi_ovfl: done");
  endtask

  task automatic test_lw_sw();
    Opcode = 4'd8; MemReady = 1'b1;
    cyc(); cyc();
    #1 exp_v = ev(4, 0,0,0,0,0,0,0,0,1,2,2,1,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL lw_addr: got %h want %h", obs, exp_v); end
    cyc();
    for (int i = 0; i < 4; i++) begin
      MemReady = (i == 3);
      #1 exp_v = ev(5, 0,0,1,1,0,0,0,0,0,0,0,0,0, ce, 0);
      cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL lw_rd%0d: got %h want %h", i, obs, exp_v); end
      cyc();
    end
    #1 exp_v = ev(8, 0,0,0,0,0,0,1,1,0,0,0,0,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL lw_wb: got %h want %h", obs, exp_v); end
    cyc();
    Opcode = 4'd9;
    cyc(); cyc(); cyc();
    #1 exp_v = ev(6, 0,0,1,0,1,0,0,0,0,0,0,0,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL sw_wr: got %h want %h", obs, exp_v); end
    cyc();
    #1 exp_v = ev(0, 1,0,0,1,0,1,0,0,0,0,0,0,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL sw_refetch: got %h want %h", obs, exp_v); end
    $display("test_lw_sw: done");
  endtask

  task automatic test_branch_jump();
    int opc [4] = '{10, 10, 11, 11};
    int zr  [4] = '{1, 0, 1, 0};
    int tk  [4] = '{1, 0, 0, 1};
    MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Opcode = 4'(opc[i]); Zero = zr[i][0];
      cyc(); cyc();
      #1 exp_v = ev(9, tk[i],tk[i],0,0,0,0,0,0,1,0,3,0,0, ce, 0);
      cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL branch op%0d z%0d: got %h want %h", opc[i], zr[i], obs, exp_v); end
      cyc();
      #1 cmp_cnt++; if (State !== 4'd0) begin err_cnt++; $display("FAIL branch_refetch: got %0d want 0", State); end
    end
    Zero = 1'b0; Opcode = 4'd12;
    cyc(); cyc();
    #1 exp_v = ev(10, 1,2,0,0,0,0,0,0,0,0,0,0,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL jump: got %h want %h", obs, exp_v); end
    cyc();
    $display("test_branch_jump: done");
  endtask

  task automatic test_fetch_timeout();
    MemReady = 1'b0; Opcode = 4'd12;
    for (int i = 0; i < 15; i++) begin
      #1 exp_v = ev(0, 0,0,0,1,0,0,0,0,0,0,0,0,0, ce, 0);
      cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL timeout_wait%0d: got %h want %h", i, obs, exp_v); end
      cyc();
    end
    ce = 3;
    #1 exp_v = ev(11, 1,3,0,0,0,0,0,0,0,0,0,0,1, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL timeout_exc: got %h want %h", obs, exp_v); end
    cyc();
    for (int i = 0; i < 15; i++) begin
      MemReady = (i == 14);
      cyc();
    end
    #1 exp_v = ev(1, 0,0,0,0,0,0,0,0,0,3,2,1,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL timeout_edge_ready: got %h want %h", obs, exp_v); end
    MemReady = 1'b1;
    cyc(); cyc();
    $display("test_fetch_timeout: done");
  endtask

  task automatic test_illegal_halt();
    Opcode = 4'd13; MemReady = 1'b1;
    cyc(); cyc(); ce = 2;
    #1 exp_v = ev(11, 1,3,0,0,0,0,0,0,0,0,0,0,1, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL illegal_exc: got %h want %h", obs, exp_v); end
    cyc();
    Opcode = 4'd15;
    cyc(); cyc();
    for (int i = 0; i < 20; i++) begin
      #1 exp_v = ev(12, 0,0,0,0,0,0,0,0,0,0,0,0,0, ce, 1);
      cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL halt%0d: got %h want %h", i, obs, exp_v); end
      cyc();
    end
    Reset = 1'b1;
    #1 exp_v = ev(12, 0,0,0,0,0,0,0,0,0,0,0,0,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL halt_reset_gate: got %h want %h", obs, exp_v); end
    cyc(); ce = 0;
    #1 exp_v = ev(0, 0,0,0,0,0,0,0,0,0,0,0,0,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL halt_reset_state: got %h want %h", obs, exp_v); end
    Reset = 1'b0;
    #1 exp_v = ev(0, 1,0,0,1,0,1,0,0,0,0,0,0,0, ce, 0);
    cmp_cnt++; if (obs !== exp_v) begin err_cnt++; $display("FAIL halt_reset_fetch: got %h want %h", obs, exp_v); end
    $display("test_illegal_halt: done");
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_addi_ovfl();
    test_lw_sw();
    test_branch_jump();
    test_fetch_timeout();
    test_illegal_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
